axi_ram_wcmd_queue: RTL and testbench
=====================================

AXI_RAM_WCMD_QUEUE -- requirements
Module: axi_ram_wcmd_queue

Interface
REQ-001 SHALL have parameter C_ID, default 16: AXI ID width.
REQ-002 SHALL have parameter C_RAM_AW, default 15: RAM address MSB index; the address field is C_RAM_AW+1 bits wide.
REQ-003 SHALL have parameter C_DEPTH_AW, default 3: queue depth is 2^C_DEPTH_AW entries, legal range 1..6.
REQ-004 SHALL have parameter C_AFULL, default 4: ram_cmd_afull asserts when level >= C_AFULL, legal range 1..2^C_DEPTH_AW.
REQ-005 SHALL have parameter C_LAST_GATE, default 1: 1 holds a last beat until bresp_fifo_full is low; 0 applies no gating.
REQ-006 aclk_s  in  1  single clock; every flop is rising-edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 ram_cmd_info_i  in  C_ID+C_RAM_AW+2  entry, packed as {last, id, addr}: addr in [C_RAM_AW:0], id above it, last in the MSB.
REQ-009 ram_cmd_push  in  1  write entry.
REQ-010 ram_wr_ack  in  1  RAM accepted the head beat.
REQ-011 bresp_fifo_full  in  1  B-response FIFO cannot accept.
REQ-012 ram_cmd_full  out  1  queue full.
REQ-013 ram_cmd_afull  out  1  level >= C_AFULL.
REQ-014 ram_cmd_level  out  C_DEPTH_AW+1  occupancy.
REQ-015 ram_wr_req  out  1  head beat valid to RAM.
REQ-016 ram_addr  out  C_RAM_AW+1  head address.
REQ-017 axi_id  out  C_ID  head ID.
REQ-018 bresp_push  out  1  push one B response.
REQ-019 bresp_id  out  C_ID  ID for the B response.
REQ-020 beat_cnt  out  8  beats acked in the current burst (saturates at 255).
REQ-021 ovf_err  out  1  sticky: push attempted while full.
REQ-022 ack_err  out  1  sticky: ram_wr_ack received while ram_wr_req is low.

Function
REQ-023 Storage SHALL be a register array with rd/wr pointers C_DEPTH_AW+1 bits wide; full when the MSBs differ and the rest are equal; empty when the pointers are equal; pointers wrap naturally.
REQ-024 The queue SHALL be first-word-fall-through: ram_addr, axi_id and the head's last bit are read combinationally at rd_ptr, so a push into an empty queue at cycle N shows ram_wr_req=1 at N+1.
REQ-025 ram_wr_req SHALL equal ~empty & ~(C_LAST_GATE & head_last & bresp_fifo_full).
REQ-026 pop SHALL equal ram_wr_ack & ram_wr_req; an ack while ram_wr_req is low SHALL NOT pop and SHALL set ack_err.
REQ-027 A push when full SHALL be dropped and SHALL set ovf_err, except that push and pop in the same cycle while full SHALL both succeed.
REQ-028 Push and pop in the same cycle at any other level SHALL leave the level unchanged; a push when empty SHALL NOT fall through the same cycle.
REQ-029 ram_cmd_level, ram_cmd_full and ram_cmd_afull SHALL be registered and SHALL reflect the state after the current edge's push/pop.
REQ-030 bresp_push SHALL be combinational (pop & head_last), asserted the same cycle as the ack; bresp_id SHALL equal axi_id.
REQ-031 beat_cnt SHALL increment on each non-last pop and clear to 0 on a last pop.
REQ-032 ovf_err and ack_err SHALL be cleared only by rst.

Reset
REQ-033 On rst the pointers and beat_cnt SHALL be 0, ovf_err and ack_err 0, level 0, full and afull 0, hence ram_wr_req and bresp_push 0.
REQ-034 rst asserted mid-burst SHALL discard all entries; array contents need no reset.

Structure
REQ-035 A shared package axi_ram_pkg SHALL hold the command-info field offsets and width functions, reused by the read-command and B-response blocks.
REQ-036 The queue core SHALL be the sub-module axi_ram_sync_fifo (parametrised width/depth, FWFT, level output); the gating, B-response and error logic SHALL wrap it.

Verification
REQ-037 Push 3 beats (last=0,0,1; id=0x5; addr 0x10,0x11,0x12) with ack every cycle -> ram_wr_req from cycle 1, beat_cnt 0→1→2→0, bresp_push=1 with bresp_id=0x5 on the third ack only.
REQ-038 Depth 8, C_AFULL=4, 8 pushes, no ack -> afull at level 4, full at level 8; a 9th push sets ovf_err and level stays 8.
REQ-039 Full queue, push and ack in the same cycle -> level stays 8, ovf_err stays 0, new entry is read out last.
REQ-040 Head last=1, bresp_fifo_full=1 -> ram_wr_req=0 with C_LAST_GATE=1 and 1 with C_LAST_GATE=0; with gate=1, drop full → request next cycle.
REQ-041 ack with the queue empty -> no pointer change, ack_err=1 until rst.
REQ-042 rst asserted after 2 of 4 beats -> next cycle level=0, ram_wr_req=0, beat_cnt=0, errors cleared.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared AXI RAM command definitions: command-info field layout and width helpers
// used by the write-command, read-command and B-response blocks.
package axi_ram_pkg;

    // Command info is packed as {last, id, addr}, with addr occupying bits [ram_aw:0].
    function automatic int cmd_addr_lsb();
        return 0;
    endfunction

    function automatic int cmd_id_lsb(input int ram_aw);
        return ram_aw + 1;
    endfunction

    function automatic int cmd_last_bit(input int id_w, input int ram_aw);
        return id_w + ram_aw + 1;
    endfunction

    function automatic int cmd_info_w(input int id_w, input int ram_aw);
        return id_w + ram_aw + 2;
    endfunction

endpackage

// File: rtl/axi_ram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered level, full and almost-full flags.
module axi_ram_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH_AW = 3,
    parameter int AFULL    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                push,
    input  logic                pop,
    output logic [WIDTH-1:0]    rd_data,
    output logic                full,
    output logic                empty,
    output logic                afull,
    output logic [DEPTH_AW:0]   level
);

    localparam int DEPTH = 1 << DEPTH_AW;
    localparam logic [DEPTH_AW:0] AFULL_LVL = AFULL[DEPTH_AW:0];

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_AW:0] wr_ptr;
    logic [DEPTH_AW:0] rd_ptr;
    logic [DEPTH_AW:0] level_q;
    logic [DEPTH_AW:0] level_nxt;
    logic              afull_q;
    logic              wr_en;
    logic              rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_AW] != rd_ptr[DEPTH_AW]) &&
                   (wr_ptr[DEPTH_AW-1:0] == rd_ptr[DEPTH_AW-1:0]);

    // A push into a full queue still lands when the head leaves in the same cycle.
    assign rd_en     = pop & ~empty;
    assign wr_en     = push & (~full | rd_en);
    assign level_nxt = level_q + {{DEPTH_AW{1'b0}}, wr_en} - {{DEPTH_AW{1'b0}}, rd_en};

    assign rd_data = mem[rd_ptr[DEPTH_AW-1:0]];
    assign level   = level_q;
    assign afull   = afull_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level_q <= level_nxt;
            afull_q <= (level_nxt >= AFULL_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axi_ram_wcmd_queue.sv
// AXI RAM write-command queue: FWFT beat queue with last-beat gating against a full
// B-response FIFO, B-response generation, burst beat counting and sticky error flags.
module axi_ram_wcmd_queue
    import axi_ram_pkg::*;
#(
    parameter int C_ID        = 16,
    parameter int C_RAM_AW    = 15,
    parameter int C_DEPTH_AW  = 3,
    parameter int C_AFULL     = 4,
    parameter int C_LAST_GATE = 1
) (
    input  logic                      aclk_s,
    input  logic                      rst,
    input  logic [C_ID+C_RAM_AW+1:0]  ram_cmd_info_i,
    input  logic                      ram_cmd_push,
    input  logic                      ram_wr_ack,
    input  logic                      bresp_fifo_full,
    output logic                      ram_cmd_full,
    output logic                      ram_cmd_afull,
    output logic [C_DEPTH_AW:0]       ram_cmd_level,
    output logic                      ram_wr_req,
    output logic [C_RAM_AW:0]         ram_addr,
    output logic [C_ID-1:0]           axi_id,
    output logic                      bresp_push,
    output logic [C_ID-1:0]           bresp_id,
    output logic [7:0]                beat_cnt,
    output logic                      ovf_err,
    output logic                      ack_err
);

    localparam int   INFO_W   = cmd_info_w(C_ID, C_RAM_AW);
    localparam int   ADDR_LSB = cmd_addr_lsb();
    localparam int   ID_LSB   = cmd_id_lsb(C_RAM_AW);
    localparam int   LAST_BIT = cmd_last_bit(C_ID, C_RAM_AW);
    localparam logic GATE_EN  = (C_LAST_GATE != 0);

    logic [INFO_W-1:0] head_info;
    logic              empty;
    logic              head_last;
    logic              pop;

    axi_ram_sync_fifo #(
        .WIDTH    (INFO_W),
        .DEPTH_AW (C_DEPTH_AW),
        .AFULL    (C_AFULL)
    ) u_fifo (
        .clk     (aclk_s),
        .rst     (rst),
        .wr_data (ram_cmd_info_i),
        .push    (ram_cmd_push),
        .pop     (pop),
        .rd_data (head_info),
        .full    (ram_cmd_full),
        .empty   (empty),
        .afull   (ram_cmd_afull),
        .level   (ram_cmd_level)
    );

    assign head_last = head_info[LAST_BIT];
    assign ram_addr  = head_info[ADDR_LSB +: C_RAM_AW+1];
    assign axi_id    = head_info[ID_LSB +: C_ID];

    // A last beat is held back while its B response would have nowhere to go.
    assign ram_wr_req = ~empty & ~(GATE_EN & head_last & bresp_fifo_full);
    assign pop        = ram_wr_ack & ram_wr_req;
    assign bresp_push = pop & head_last;
    assign bresp_id   = axi_id;

    always_ff @(posedge aclk_s) begin
        if (rst) begin
            beat_cnt <= '0;
            ovf_err  <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            if (pop) begin
                if (head_last)              beat_cnt <= '0;
                else if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
            end
            if (ram_cmd_push & ram_cmd_full & ~pop) ovf_err <= 1'b1;
            if (ram_wr_ack & ~ram_wr_req)           ack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_ram_wcmd_queue.sv
// Self-checking bench for axi_ram_wcmd_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_axi_ram_wcmd_queue;

    localparam int ID_W   = 16;
    localparam int AW     = 15;
    localparam int INFO_W = ID_W + AW + 2;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [INFO_W-1:0] ram_cmd_info_i = '0;
    logic              ram_cmd_push = 1'b0;
    logic              ram_wr_ack = 1'b0;
    logic              bresp_fifo_full = 1'b0;
    logic              ram_cmd_full;
    logic              ram_cmd_afull;
    logic [3:0]        ram_cmd_level;
    logic              ram_wr_req;
    logic [AW:0]       ram_addr;
    logic [ID_W-1:0]   axi_id;
    logic              bresp_push;
    logic [ID_W-1:0]   bresp_id;
    logic [7:0]        beat_cnt;
    logic              ovf_err;
    logic              ack_err;

    logic              g0_rst = 1'b1;
    logic [INFO_W-1:0] g0_info = '0;
    logic              g0_push = 1'b0;
    logic              g0_ack = 1'b0;
    logic              g0_bf = 1'b0;
    logic              g0_full;
    logic              g0_afull;
    logic [3:0]        g0_level;
    logic              g0_req;
    logic [AW:0]       g0_addr;
    logic [ID_W-1:0]   g0_id;
    logic              g0_bpush;
    logic [ID_W-1:0]   g0_bid;
    logic [7:0]        g0_beat;
    logic              g0_ovf;
    logic              g0_ack_err;

    int total = 0;
    int bad   = 0;

    logic [INFO_W-1:0] mq[$];
    int                m_beat = 0;
    bit                m_ovf = 0;
    bit                m_ack_err = 0;

    always #5 clk = ~clk;

    axi_ram_wcmd_queue #(
        .C_ID(ID_W), .C_RAM_AW(AW), .C_DEPTH_AW(3), .C_AFULL(AFULL), .C_LAST_GATE(1)
    ) dut (
        .aclk_s          (clk),
        .rst             (rst),
        .ram_cmd_info_i  (ram_cmd_info_i),
        .ram_cmd_push    (ram_cmd_push),
        .ram_wr_ack      (ram_wr_ack),
        .bresp_fifo_full (bresp_fifo_full),
        .ram_cmd_full    (ram_cmd_full),
        .ram_cmd_afull   (ram_cmd_afull),
        .ram_cmd_level   (ram_cmd_level),
        .ram_wr_req      (ram_wr_req),
        .ram_addr        (ram_addr),
        .axi_id          (axi_id),
        .bresp_push      (bresp_push),
        .bresp_id        (bresp_id),
        .beat_cnt        (beat_cnt),
        .ovf_err         (ovf_err),
        .ack_err         (ack_err)
    );

    axi_ram_wcmd_queue #(
        .C_ID(ID_W), .C_RAM_AW(AW), .C_DEPTH_AW(3), .C_AFULL(AFULL), .C_LAST_GATE(0)
    ) dut_nogate (
        .aclk_s          (clk),
        .rst             (g0_rst),
        .ram_cmd_info_i  (g0_info),
        .ram_cmd_push    (g0_push),
        .ram_wr_ack      (g0_ack),
        .bresp_fifo_full (g0_bf),
        .ram_cmd_full    (g0_full),
        .ram_cmd_afull   (g0_afull),
        .ram_cmd_level   (g0_level),
        .ram_wr_req      (g0_req),
        .ram_addr        (g0_addr),
        .axi_id          (g0_id),
        .bresp_push      (g0_bpush),
        .bresp_id        (g0_bid),
        .beat_cnt        (g0_beat),
        .ovf_err         (g0_ovf),
        .ack_err         (g0_ack_err)
    );

    function automatic logic [INFO_W-1:0] mk(input bit last, input int id, input int addr);
        logic [ID_W-1:0] i16;
        logic [AW:0]     a16;
        i16 = id[ID_W-1:0];
        a16 = addr[AW:0];
        return {last, i16, a16};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model view of the head entry and the request/pop it implies for the current inputs.
    function automatic bit model_req();
        if (mq.size() == 0) return 0;
        return !(mq[0][INFO_W-1] && bresp_fifo_full);
    endfunction

    task automatic checkOutput();
        bit req;
        bit pop;
        bit last;
        req  = model_req();
        pop  = req && ram_wr_ack;
        last = (mq.size() != 0) ? mq[0][INFO_W-1] : 1'b0;
        check("ram_wr_req", ram_wr_req, req);
        if (req) begin
            check("ram_addr", ram_addr, mq[0][AW:0]);
            check("axi_id", axi_id, mq[0][INFO_W-2:AW+1]);
        end
        check("bresp_push", bresp_push, pop && last);
        if (pop && last) check("bresp_id", bresp_id, mq[0][INFO_W-2:AW+1]);
        check("level", ram_cmd_level, mq.size());
        check("full", ram_cmd_full, mq.size() == DEPTH);
        check("afull", ram_cmd_afull, mq.size() >= AFULL);
        check("beat_cnt", beat_cnt, m_beat);
        check("ovf_err", ovf_err, m_ovf);
        check("ack_err", ack_err, m_ack_err);
    endtask

    task automatic modelUpdate();
        bit req;
        bit pop;
        bit was_full;
        if (rst) begin
            mq.delete();
            m_beat = 0;
            m_ovf = 0;
            m_ack_err = 0;
        end else begin
            req      = model_req();
            pop      = req && ram_wr_ack;
            was_full = (mq.size() == DEPTH);
            if (ram_wr_ack && !req) m_ack_err = 1;
            if (ram_cmd_push && was_full && !pop) m_ovf = 1;
            if (pop) begin
                if (mq[0][INFO_W-1]) m_beat = 0;
                else if (m_beat < 255) m_beat++;
                void'(mq.pop_front());
            end
            if (ram_cmd_push && (!was_full || pop)) mq.push_back(ram_cmd_info_i);
        end
    endtask

    task automatic applyStimulus(input bit p, input logic [INFO_W-1:0] info,
                                 input bit a, input bit bf, input bit r);
        @(negedge clk);
        ram_cmd_push    = p;
        ram_cmd_info_i  = info;
        ram_wr_ack      = a;
        bresp_fifo_full = bf;
        rst             = r;
        #1;
        checkOutput();
        modelUpdate();
    endtask

    task automatic idle();
        applyStimulus(0, '0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, '0, 0, 0, 1);
    endtask

    initial begin
        // Ungated instance: a last beat goes out even with the B FIFO full.
        @(negedge clk);
        g0_rst = 0; g0_push = 1; g0_info = mk(1, 9, 'h33); g0_bf = 1;
        @(negedge clk);
        g0_push = 0;
        #1;
        check("g0_req_ungated", g0_req, 1);
        check("g0_addr", g0_addr, 'h33);
        g0_ack = 1;
        #1;
        check("g0_bresp_push", g0_bpush, 1);
        check("g0_bresp_id", g0_bid, 9);
        @(negedge clk);
        g0_ack = 0;
        #1;
        check("g0_level_after", g0_level, 0);
        check("g0_ack_err", g0_ack_err, 0);

        // Main instance has been in reset for several edges by now.
        idle();
        check("reset_req", ram_wr_req, 0);
        check("reset_level", ram_cmd_level, 0);
        check("reset_beat", beat_cnt, 0);

        // Three-beat burst with ack following each push.
        applyStimulus(1, mk(0, 5, 'h10), 0, 0, 0);
        check("burst_no_fallthrough", ram_wr_req, 0);
        applyStimulus(1, mk(0, 5, 'h11), 1, 0, 0);
        check("burst_req_c1", ram_wr_req, 1);
        check("burst_addr0", ram_addr, 'h10);
        check("burst_beat0", beat_cnt, 0);
        applyStimulus(1, mk(1, 5, 'h12), 1, 0, 0);
        check("burst_addr1", ram_addr, 'h11);
        check("burst_beat1", beat_cnt, 1);
        check("burst_bpush_mid", bresp_push, 0);
        applyStimulus(0, '0, 1, 0, 0);
        check("burst_addr2", ram_addr, 'h12);
        check("burst_beat2", beat_cnt, 2);
        check("burst_bpush_last", bresp_push, 1);
        check("burst_bid", bresp_id, 5);
        idle();
        check("burst_beat_clr", beat_cnt, 0);
        check("burst_empty", ram_cmd_level, 0);

        // Fill to full, then overflow.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, mk(0, i, 'h30 + i), 0, 0, 0);
            if (i == 3) check("afull_at3", ram_cmd_afull, 0);
            if (i == 4) begin
                check("afull_at4", ram_cmd_afull, 1);
                check("level_at4", ram_cmd_level, 4);
            end
        end
        applyStimulus(1, mk(0, 99, 'h3F), 0, 0, 0);
        check("full_at8", ram_cmd_full, 1);
        idle();
        check("ovf_set", ovf_err, 1);
        check("ovf_level", ram_cmd_level, 8);

        // Full queue with simultaneous push and pop.
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, mk(0, 2, 'h40 + i), 0, 0, 0);
        applyStimulus(1, mk(0, 2, 'h7F), 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, '0, 1, 0, 0);
            if (i == 0) begin
                check("pp_full_level", ram_cmd_level, 8);
                check("pp_no_ovf", ovf_err, 0);
            end
            if (i == 7) check("pp_new_last", ram_addr, 'h7F);
        end
        idle();

        // Last beat held by a full B FIFO until it drains.
        doReset();
        applyStimulus(1, mk(1, 3, 'h20), 0, 1, 0);
        applyStimulus(0, '0, 0, 1, 0);
        check("gate_hold", ram_wr_req, 0);
        applyStimulus(0, '0, 1, 0, 0);
        check("gate_release", ram_wr_req, 1);
        check("gate_bpush", bresp_push, 1);
        check("gate_bid", bresp_id, 3);

        // Stray ack on an empty queue, then reset mid-burst.
        doReset();
        applyStimulus(0, '0, 1, 0, 0);
        idle();
        check("ack_err_set", ack_err, 1);
        check("ack_err_level", ram_cmd_level, 0);
        repeat (3) idle();
        check("ack_err_sticky", ack_err, 1);
        applyStimulus(1, mk(0, 7, 'h50), 0, 0, 0);
        applyStimulus(1, mk(0, 7, 'h51), 1, 0, 0);
        applyStimulus(1, mk(0, 7, 'h52), 1, 0, 0);
        applyStimulus(1, mk(1, 7, 'h53), 0, 0, 0);
        check("midburst_beat", beat_cnt, 2);
        doReset();
        idle();
        check("rst_level", ram_cmd_level, 0);
        check("rst_req", ram_wr_req, 0);
        check("rst_beat", beat_cnt, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_ovf", ovf_err, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) < 50,
                          mk($urandom_range(0, 2) == 0, $urandom, $urandom),
                          $urandom_range(0, 99) < 55,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
